// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared states, coil bit order and full-step phase table
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Bit positions within coils = {A+, B+, A-, B-}
  localparam int COIL_A_POS = 3;
  localparam int COIL_B_POS = 2;
  localparam int COIL_A_NEG = 1;
  localparam int COIL_B_NEG = 0;

  localparam logic [3:0] PHASE_TABLE [4] = '{
    (4'b1 << COIL_A_POS) | (4'b1 << COIL_B_POS),
    (4'b1 << COIL_B_POS) | (4'b1 << COIL_A_NEG),
    (4'b1 << COIL_A_NEG) | (4'b1 << COIL_B_NEG),
    (4'b1 << COIL_A_POS) | (4'b1 << COIL_B_NEG)
  };

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - reloadable down-counter that parks at zero
module step_timer #(
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tick_zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_zero = (count_q == '0);

endmodule

// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - paced full-step bipolar stepper driver with hold torque
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_PERIOD = 100000,
  parameter int MIN_PERIOD  = 5000,
  parameter int HOLD_CYCLES = 1000000,
  parameter int PERIOD_W    = 20,
  parameter int STEPS_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          coils,
  output logic [1:0]          enable,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STEPS_W-1:0]  position
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [STEPS_W-1:0]   pos_q, pos_d;
  logic [STEPS_W-1:0]   rem_q, rem_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic                 dir_q, dir_d;
  logic                 abflag_q, abflag_d;
  logic [3:0]           coils_q, coils_d;
  logic [1:0]           enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic                 accept;
  logic [PERIOD_W-1:0]  req_period, eff_period;
  logic                 step_load, step_zero;
  logic [PERIOD_W-1:0]  step_value;
  logic                 hold_load, hold_zero;

  assign cmd_ready = (state_q == IDLE) || (state_q == HOLD);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    req_period = (cmd_period == '0) ? PERIOD_W'(STEP_PERIOD) : cmd_period;
    eff_period = (req_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : req_period;
  end

  step_timer #(.W(PERIOD_W)) u_step_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (step_load),
    .value     (step_value),
    .tick_zero (step_zero)
  );

  step_timer #(.W(HOLD_W)) u_hold_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (hold_load),
    .value     (HOLD_W'(HOLD_CYCLES - 1)),
    .tick_zero (hold_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    rem_d      = rem_q;
    period_d   = period_q;
    dir_d      = dir_q;
    abflag_d   = abflag_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    step_load  = 1'b0;
    step_value = period_q;
    hold_load  = 1'b0;

    // A command accepted in HOLD also completes the previous move
    if (accept) begin
      done_d    = 1'b1;
      aborted_d = (state_q == HOLD) ? abflag_q : 1'b0;
      if (state_q == IDLE && cmd_steps != '0) begin
        done_d = 1'b0;
      end
      abflag_d = 1'b0;
      period_d = eff_period - 1'b1;
      rem_d    = cmd_steps;
      dir_d    = cmd_dir;
      if (cmd_steps != '0) begin
        state_d    = RUN;
        step_load  = 1'b1;
        step_value = eff_period - 1'b1;
      end else if (state_q == HOLD) begin
        hold_load = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (abort) begin
            state_d   = HOLD;
            hold_load = 1'b1;
            abflag_d  = 1'b1;
          end else if (step_zero) begin
            idx_d     = dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
            pos_d     = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
            rem_d     = rem_q - 1'b1;
            step_load = 1'b1;
            if (rem_q == STEPS_W'(1)) begin
              state_d   = HOLD;
              hold_load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_zero) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = abflag_q;
            abflag_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    coils_d  = (state_d == IDLE) ? 4'b0000 : PHASE_TABLE[idx_d];
    enable_d = (state_d == IDLE) ? 2'b00 : 2'b11;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      pos_q     <= '0;
      rem_q     <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      abflag_q  <= 1'b0;
      coils_q   <= 4'b0000;
      enable_q  <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      abflag_q  <= abflag_d;
      coils_q   <= coils_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign coils    = coils_q;
  assign enable   = enable_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign position = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - directed self-checking bench for stepper_sequencer
module tb_stepper_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [19:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic [3:0]  coils;
  logic [1:0]  enable;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] position;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  stepper_sequencer #(
    .STEP_PERIOD (20),
    .MIN_PERIOD  (4),
    .HOLD_CYCLES (8),
    .PERIOD_W    (20),
    .STEPS_W     (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_period (cmd_period),
    .abort      (abort),
    .coils      (coils),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Park at the falling edge that follows rising edge number t
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Called at a falling edge; acc returns the number of the accepting rising edge
  task automatic send(input int steps, input bit dir, input int period, output int acc);
    cmd_steps  = steps[15:0];
    cmd_dir    = dir;
    cmd_period = period[19:0];
    cmd_valid  = 1'b1;
    acc        = cyc + 1;
    @(negedge clock);
    cmd_valid  = 1'b0;
    cmd_steps  = 16'h5555;
    cmd_dir    = ~dir;
    cmd_period = 20'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;

    // 1: reset and idle
    do_reset();
    chk("rst_coils", {28'd0, coils}, 32'h0);
    chk("rst_enable", {30'd0, enable}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'h1);
    chk("rst_pos", {16'd0, position}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);

    // 2: three forward steps, period 10
    send(3, 1'b1, 10, a);
    chk("t2_acc_coils", {28'd0, coils}, 32'hC);
    chk("t2_acc_busy", {31'd0, busy}, 32'h1);
    chk("t2_acc_ready", {31'd0, cmd_ready}, 32'h0);
    wait_until(a + 9);
    chk("t2_pre_coils", {28'd0, coils}, 32'hC);
    wait_until(a + 10);
    chk("t2_s1_coils", {28'd0, coils}, 32'h6);
    wait_until(a + 20);
    chk("t2_s2_coils", {28'd0, coils}, 32'h3);
    wait_until(a + 30);
    chk("t2_s3_coils", {28'd0, coils}, 32'h9);
    chk("t2_s3_pos", {16'd0, position}, 32'd3);
    wait_until(a + 37);
    chk("t2_hold_en", {30'd0, enable}, 32'h3);
    chk("t2_hold_done", {31'd0, done}, 32'h0);
    wait_until(a + 38);
    chk("t2_end_en", {30'd0, enable}, 32'h0);
    chk("t2_end_coils", {28'd0, coils}, 32'h0);
    chk("t2_end_done", {31'd0, done}, 32'h1);
    chk("t2_end_abt", {31'd0, aborted}, 32'h0);
    chk("t2_end_busy", {31'd0, busy}, 32'h0);
    wait_until(a + 39);
    chk("t2_done_clr", {31'd0, done}, 32'h0);

    // 3: two reverse steps at default period, position wraps
    do_reset();
    send(2, 1'b0, 0, a);
    wait_until(a + 19);
    chk("t3_pre_pos", {16'd0, position}, 32'h0);
    wait_until(a + 20);
    chk("t3_s1_pos", {16'd0, position}, 32'hFFFF);
    chk("t3_s1_coils", {28'd0, coils}, 32'h9);
    wait_until(a + 40);
    chk("t3_s2_pos", {16'd0, position}, 32'hFFFE);
    chk("t3_s2_coils", {28'd0, coils}, 32'h3);
    wait_until(a + 48);
    chk("t3_done", {31'd0, done}, 32'h1);

    // 4: period clamped to 4, abort at +13 -> three steps, then hold 8
    send(100, 1'b1, 2, a);
    wait_until(a + 4);
    chk("t4_s1_pos", {16'd0, position}, 32'hFFFF);
    wait_until(a + 12);
    chk("t4_s3_pos", {16'd0, position}, 32'h1);
    chk("t4_s3_coils", {28'd0, coils}, 32'h6);
    abort = 1'b1;
    wait_until(a + 13);
    abort = 1'b0;
    chk("t4_abt_busy", {31'd0, busy}, 32'h1);
    chk("t4_abt_ready", {31'd0, cmd_ready}, 32'h1);
    wait_until(a + 16);
    chk("t4_nostep_pos", {16'd0, position}, 32'h1);
    wait_until(a + 20);
    chk("t4_hold_en", {30'd0, enable}, 32'h3);
    chk("t4_hold_done", {31'd0, done}, 32'h0);
    wait_until(a + 21);
    chk("t4_done", {31'd0, done}, 32'h1);
    chk("t4_aborted", {31'd0, aborted}, 32'h1);
    chk("t4_end_en", {30'd0, enable}, 32'h0);

    // 5: chained move accepted two cycles into HOLD
    send(2, 1'b1, 4, a);
    for (int k = a + 1; k <= a + 9; k++) begin
      wait_until(k);
      chk("t5_en_run1", {30'd0, enable}, 32'h3);
    end
    chk("t5_pos1", {16'd0, position}, 32'd3);
    send(1, 1'b0, 5, b);
    chk("t5_acc_done", {31'd0, done}, 32'h1);
    chk("t5_acc_abt", {31'd0, aborted}, 32'h0);
    chk("t5_acc_busy", {31'd0, busy}, 32'h1);
    for (int k = b + 1; k <= b + 12; k++) begin
      wait_until(k);
      chk("t5_en_run2", {30'd0, enable}, 32'h3);
      if (k == b + 1) chk("t5_done_clr", {31'd0, done}, 32'h0);
      if (k == b + 5) begin
        chk("t5_pos2", {16'd0, position}, 32'd2);
        chk("t5_coils2", {28'd0, coils}, 32'h3);
      end
    end
    wait_until(b + 13);
    chk("t5_done", {31'd0, done}, 32'h1);
    chk("t5_end_en", {30'd0, enable}, 32'h0);

    // 6: zero-step command, then reset in the middle of a move
    wait_until(b + 15);
    send(0, 1'b1, 0, a);
    chk("t6_zero_done", {31'd0, done}, 32'h1);
    chk("t6_zero_abt", {31'd0, aborted}, 32'h0);
    chk("t6_zero_busy", {31'd0, busy}, 32'h0);
    wait_until(a + 1);
    chk("t6_zero_clr", {31'd0, done}, 32'h0);
    chk("t6_zero_busy2", {31'd0, busy}, 32'h0);
    chk("t6_zero_pos", {16'd0, position}, 32'd2);
    send(5, 1'b1, 4, a);
    wait_until(a + 6);
    chk("t6_run_pos", {16'd0, position}, 32'd3);
    chk("t6_run_coils", {28'd0, coils}, 32'h9);
    reset = 1'b1;
    wait_until(a + 7);
    chk("t6_rst_coils", {28'd0, coils}, 32'h0);
    chk("t6_rst_en", {30'd0, enable}, 32'h0);
    chk("t6_rst_busy", {31'd0, busy}, 32'h0);
    chk("t6_rst_pos", {16'd0, position}, 32'h0);
    chk("t6_rst_ready", {31'd0, cmd_ready}, 32'h1);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
